// File: rtl/remote_cmd_responder.sv
// Device-side end of the remote command link: 8N1 byte receiver, 16-bit command assembler and response transmitter.
// Optional feature: define CMD_TIMEOUT_EN to drop a dangling high byte after TIMEOUT_CYC idle cycles.
module remote_cmd_responder #(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int            CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {WAIT_HIGH, WAIT_LOW} byte_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    // ------------------------------------------------------------------
    // RX engine
    // ------------------------------------------------------------------
    rx_state_t     rx_state;
    rx_state_t     rx_next;
    logic          rx_m;
    logic          rx_s;
    logic          rx_q;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_half;
    logic          rx_full;
    logic          rx_cnt_clr;
    logic          start_acc;
    logic          byte_done;
    logic          frame_err;

    assign rx_half = (rx_cnt == HALF_LAST);
    assign rx_full = (rx_cnt == BIT_LAST);

    // Synchroniser and edge-detect flops preset high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s && rx_q) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_full) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        start_acc  = 1'b0;
        byte_done  = 1'b0;
        frame_err  = 1'b0;
        rx_cnt_clr = 1'b0;
        case (rx_state)
            RX_IDLE: rx_cnt_clr = 1'b1;
            RX_START: begin
                start_acc  = rx_half && !rx_s;
                rx_cnt_clr = rx_half;
            end
            RX_DATA: rx_cnt_clr = rx_full;
            RX_STOP: begin
                byte_done  = rx_full && rx_s;
                frame_err  = rx_full && !rx_s;
                rx_cnt_clr = rx_full;
            end
            default: rx_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_cnt <= rx_cnt_clr ? '0 : rx_cnt + 1'b1;
            if (rx_state != RX_DATA) begin
                rx_bit <= '0;
            end else if (rx_full) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte FSM and command register
    // ------------------------------------------------------------------
    byte_state_t byte_state;
    byte_state_t byte_next;
    logic [7:0]  high_reg;
    logic        load_high;
    logic        load_cmd;
    logic        new_cmd_start;
    logic        timeout;

    always_ff @(posedge clk) begin
        if (rst) byte_state <= WAIT_HIGH;
        else     byte_state <= byte_next;
    end

    always_comb begin
        byte_next = byte_state;
        case (byte_state)
            WAIT_HIGH: if (byte_done) byte_next = WAIT_LOW;
            WAIT_LOW:  if (byte_done || frame_err || timeout) byte_next = WAIT_HIGH;
            default:   byte_next = WAIT_HIGH;
        endcase
    end

    always_comb begin
        load_high     = (byte_state == WAIT_HIGH) && byte_done;
        load_cmd      = (byte_state == WAIT_LOW) && byte_done;
        new_cmd_start = (byte_state == WAIT_HIGH) && start_acc;
    end

`ifdef CMD_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] to_cnt;
    logic          low_started;

    // Counting stops once the low byte's start bit is accepted; that byte always finishes.
    always_ff @(posedge clk) begin
        if (rst || byte_state != WAIT_LOW) begin
            to_cnt      <= '0;
            low_started <= 1'b0;
        end else begin
            if (start_acc) low_started <= 1'b1;
            if (!low_started) to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (byte_state == WAIT_LOW) && !low_started && !start_acc && (to_cnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    // A completed command beats a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_reg <= '0;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
        end else begin
            if (load_high) high_reg <= rx_shift;
            if (load_cmd) begin
                cmd     <= {high_reg, rx_shift};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || new_cmd_start) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX engine
    // ------------------------------------------------------------------
    tx_state_t     tx_state;
    tx_state_t     tx_next;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_frame;
    logic          tx_full;
    logic          tx_accept;
    logic          tx_adv;
    logic          tx_done;

    assign tx_full = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (send_resp) tx_next = TX_SHIFT;
            TX_SHIFT: if (tx_full && tx_bit == 4'd9) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_accept = (tx_state == TX_IDLE) && send_resp;
        tx_adv    = (tx_state == TX_SHIFT) && tx_full;
        tx_done   = tx_adv && (tx_bit == 4'd9);
    end

    // The start bit goes straight to TX; tx_frame keeps the remaining {stop, data} bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_frame  <= '1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else if (tx_accept) begin
            tx_frame  <= {1'b1, resp};
            tx_cnt    <= '0;
            tx_bit    <= '0;
            TX        <= 1'b0;
            resp_sent <= 1'b0;
        end else if (tx_done) begin
            tx_cnt    <= '0;
            TX        <= 1'b1;
            resp_sent <= 1'b1;
        end else if (tx_adv) begin
            tx_frame <= {1'b1, tx_frame[8:1]};
            TX       <= tx_frame[0];
            tx_bit   <= tx_bit + 1'b1;
            tx_cnt   <= '0;
        end else if (tx_state == TX_SHIFT) begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_remote_cmd_responder.sv
// Bench for remote_cmd_responder: directed RX byte streams and response requests,
// with queue-based monitors for completed commands and transmitted response frames.
`timescale 1ns/1ps
module tb_remote_cmd_responder;

    localparam int BD = 16;
    localparam int TO = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];

    remote_cmd_responder #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drivers
    task automatic rx_byte(input logic [7:0] d, input logic stop, input logic clr_at_stop);
        RX = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            tick(BD);
        end
        RX = stop;
        if (clr_at_stop) begin
            // Lands on the edge where the receiver samples the stop bit.
            tick(10);
            clr_cmd_rdy = 1'b1;
            tick(1);
            clr_cmd_rdy = 1'b0;
            tick(5);
        end else begin
            tick(BD);
        end
        RX = 1'b1;
        tick(4);
    endtask

    task automatic pulse_send(input logic [7:0] r);
        resp      = r;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
    endtask

    // Scoreboard: command monitor
    initial begin : cmd_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_rdy === 1'b1 && !prev) begin
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected: got %0h expected no command", cmd);
                end else begin
                    chk("cmd_mon", {16'h0, cmd}, {16'h0, exp_cmd_q.pop_front()});
                end
            end
            prev = (cmd_rdy === 1'b1);
        end
    end

    task automatic mon_wait(input int n, inout logic ok);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (rst) ok = 1'b0;
        end
    endtask

    // Scoreboard: TX frame monitor (frames cut by reset are dropped)
    initial begin : tx_mon
        logic       prev;
        logic       ok;
        logic       stop_bit;
        logic [7:0] got;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && TX === 1'b0) begin
                ok = 1'b1;
                mon_wait(BD / 2 - 1, ok);
                if (ok) chk("tx_start_bit", {31'h0, TX}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    mon_wait(BD, ok);
                    got[i] = TX;
                end
                mon_wait(BD, ok);
                stop_bit = TX;
                if (ok) begin
                    chk("tx_stop_bit", {31'h0, stop_bit}, 32'h1);
                    if (exp_tx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected: got %0h expected no frame", got);
                    end else begin
                        chk("tx_byte", {24'h0, got}, {24'h0, exp_tx_q.pop_front()});
                    end
                end
            end
            prev = TX;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin : stim
        logic [9:0] fr;

        rst = 1'b1;
        tick(3);
        chk("rst_tx", {31'h0, TX}, 32'h1);
        chk("rst_cmd", {16'h0, cmd}, 32'h0);
        chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("rst_resp_sent", {31'h0, resp_sent}, 32'h0);
        rst = 1'b0;
        tick(2);

        // Two bytes form a command, then acknowledge
        exp_cmd_q.push_back(16'hA53C);
        rx_byte(8'hA5, 1'b1, 1'b0);
        rx_byte(8'h3C, 1'b1, 1'b0);
        chk("t1_cmd", {16'h0, cmd}, 32'hA53C);
        chk("t1_rdy", {31'h0, cmd_rdy}, 32'h1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        chk("t1_clr_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("t1_cmd_hold", {16'h0, cmd}, 32'hA53C);

        // Response frame timing; a second request mid-frame is ignored
        fr = {1'b1, 8'hC3, 1'b0};
        exp_tx_q.push_back(8'hC3);
        pulse_send(8'hC3);
        resp = 8'h5A;
        chk("t2_tx_low", {31'h0, TX}, 32'h0);
        chk("t2_resp_sent_clr", {31'h0, resp_sent}, 32'h0);
        for (int c = 2; c <= 161; c++) begin
            send_resp = (c == 50);
            tick(1);
            if (c <= 160 && ((c - 1) % BD == 0 || (c - 1) % BD == BD - 1))
                chk("t2_tx_bit", {31'h0, TX}, {31'h0, fr[(c - 1) / BD]});
            if (c == 160) chk("t2_resp_sent_early", {31'h0, resp_sent}, 32'h0);
            if (c == 161) chk("t2_resp_sent", {31'h0, resp_sent}, 32'h1);
        end
        send_resp = 1'b0;
        tick(20);
        chk("t2_tx_idle", {31'h0, TX}, 32'h1);

        // Framing error discards the pair
        exp_cmd_q.push_back(16'h5678);
        rx_byte(8'h12, 1'b1, 1'b0);
        rx_byte(8'h34, 1'b0, 1'b0);
        chk("t3_no_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("t3_cmd_hold", {16'h0, cmd}, 32'hA53C);
        rx_byte(8'h56, 1'b1, 1'b0);
        rx_byte(8'h78, 1'b1, 1'b0);
        chk("t3_cmd", {16'h0, cmd}, 32'h5678);
        chk("t3_rdy", {31'h0, cmd_rdy}, 32'h1);

        // Reset mid low byte and mid TX frame
        rx_byte(8'hAB, 1'b1, 1'b0);
        RX = 1'b0;
        tick(20);
        pulse_send(8'h99);
        tick(30);
        rst = 1'b1;
        RX  = 1'b1;
        tick(1);
        chk("t4_tx", {31'h0, TX}, 32'h1);
        chk("t4_cmd", {16'h0, cmd}, 32'h0);
        chk("t4_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("t4_resp_sent", {31'h0, resp_sent}, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(20);
        exp_cmd_q.push_back(16'hFF00);
        rx_byte(8'hFF, 1'b1, 1'b0);
        rx_byte(8'h00, 1'b1, 1'b0);
        chk("t4_cmd_after", {16'h0, cmd}, 32'hFF00);
        chk("t4_rdy_after", {31'h0, cmd_rdy}, 32'h1);
        tick(200);

        // Full duplex; acknowledge coincident with the completing stop bit
        exp_cmd_q.push_back(16'h9A4D);
        rx_byte(8'h9A, 1'b1, 1'b0);
        exp_tx_q.push_back(8'h6E);
        fork
            rx_byte(8'h4D, 1'b1, 1'b1);
            begin
                tick(20);
                pulse_send(8'h6E);
                resp = 8'h00;
            end
        join
        chk("t6_rdy_set_wins", {31'h0, cmd_rdy}, 32'h1);
        chk("t6_cmd", {16'h0, cmd}, 32'h9A4D);
        tick(200);
        chk("t6_resp_sent", {31'h0, resp_sent}, 32'h1);

        // Inter-byte gap longer than the timeout
`ifdef CMD_TIMEOUT_EN
        exp_cmd_q.push_back(16'h2233);
`else
        exp_cmd_q.push_back(16'h1122);
`endif
        rx_byte(8'h11, 1'b1, 1'b0);
        tick(500);
        rx_byte(8'h22, 1'b1, 1'b0);
        rx_byte(8'h33, 1'b1, 1'b0);
        tick(10);
`ifdef CMD_TIMEOUT_EN
        chk("t5_cmd", {16'h0, cmd}, 32'h2233);
`else
        chk("t5_cmd", {16'h0, cmd}, 32'h1122);
`endif

        tick(20);
        chk("cmd_q_empty", exp_cmd_q.size(), 32'h0);
        chk("tx_q_empty", exp_tx_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
